filter_cache_loader: RTL and testbench
======================================

# filter_cache_loader

Write-side sequencer for the per-PE filter caches. It accepts a valid/ready stream of RAM-width filter words and issues `ram_write_request_t` beats. The beats are broadcast to every `pe_ram` instance and walk address, filter and PE in a fixed order. One load is armed by a start pulse and ends with a one-cycle done pulse, so the host/DMA side never has to compute PE, filter or address IDs.

## Interface
- `cfg`, no default, `pe_cfg_t`; uses `NUM_FILTERS`, `RAM_DEPTH`, `RAM_ADDR_WIDTH`, `RAM_WIDTH`
- `NUM_PES`, default 1, number of `pe_ram` instances sharing the write bus; PE IDs run 0..NUM_PES-1
- `clock`  in  1  sole clock
- `reset`  in  1  synchronous, active-high
- `i_start`  in  1  single-cycle pulse arming a load; sampled only in IDLE
- `i_num_words`  in  `RAM_ADDR_WIDTH+1`  words per (PE, filter); sampled with `i_start`
- `i_data_valid`  in  1  input word valid
- `i_data`  in  `RAM_WIDTH`  filter word
- `o_data_ready`  out  1  loader can accept a word
- `o_write_request`  out  `ram_write_request_t#(cfg)::t`  registered write beat (enable, pe_id, filter_id, addr, data)
- `o_busy`  out  1  high in LOAD and FLUSH
- `o_done`  out  1  one-cycle pulse, load complete

## Operation
- States: IDLE, LOAD, FLUSH.
- IDLE:
  - On `i_start`, latch `n = min(i_num_words, RAM_DEPTH)` and clear the addr, filter and pe counters.
  - If n == 0, go to FLUSH with no writes; otherwise go to LOAD.
- LOAD:
  - `o_data_ready = 1`.
  - A word is accepted when valid && ready. The accepted word is written to (pe, filter, addr).
  - Counter order: addr is innermost (0..n-1), then filter (0..NUM_FILTERS-1), then pe (0..NUM_PES-1).
  - Total beats per load = n × NUM_FILTERS × NUM_PES.
  - After accepting the last beat (addr = n-1, filter = NUM_FILTERS-1, pe = NUM_PES-1), go to FLUSH.
- FLUSH: lasts one cycle; `o_done = 1`, then return to IDLE.
- `i_start` in LOAD or FLUSH is ignored, with no effect on counters.
- Each counter wraps to 0 when it reaches its limit and carries into the next outer counter. Counters never exceed their limits, so PE and filter IDs outside range are never driven.
- Unused high bits of `pe_id` and `filter_id` are driven 0.

## Timing
- Reset values:
  - state = IDLE
  - `o_data_ready` = 0, `o_busy` = 0, `o_done` = 0
  - `o_write_request.enable` = 0
  - `o_write_request` addr, pe_id, filter_id and data = 0
- Write latency:
  - A beat accepted in cycle t produces `o_write_request.enable = 1` in cycle t+1, with the matching IDs, addr and data.
  - enable is high for exactly one cycle per accepted beat.
  - No combinational path from `i_data` to `o_write_request`.
- `o_data_ready` is registered: high from the cycle after the `i_start` sample until the cycle the last beat is accepted, inclusive.
- With continuous valid, throughput is one beat per cycle.
- A gap in valid inserts no write; counters hold.
- `o_done` is asserted in the same cycle as the final write enable, since the last beat registers as FLUSH is entered.
- For n == 0, `o_done` is asserted 1 cycle after `i_start`.
- `o_busy` is high from cycle start+1 through the `o_done` cycle, inclusive.
- `reset` mid-load: the next cycle shows reset values. Partial RAM contents are left as written; no done pulse is issued.

## Configuration
- `FILTER_CACHE_LOADER_ABORT_EN` defined:
  - Adds port `i_abort` (in, 1).
  - `i_abort` in LOAD or FLUSH forces IDLE on the next cycle and clears counters and `o_data_ready`.
  - No `o_done` pulse.
  - A write beat already registered in the abort cycle still appears. A beat accepted in the abort cycle is dropped.
- Not defined: the port is absent; a load can only be ended by completion or `reset`.

## Structure
- `pe_types` gains:
  - `filter_loader_state_t` enum (IDLE, LOAD, FLUSH)
  - a `PE_ID_WIDTH` helper function
- Sub-module `filter_cache_addr_gen`:
  - nested addr/filter/pe counters with clear, advance and `o_last` outputs
  - parameterised by cfg and NUM_PES
  - reused later by the read-side scheduler.

## Test plan
1. NUM_PES = 2, NUM_FILTERS = 2, RAM_DEPTH = 4, n = 3, continuous valid with data 0..11:
   - 12 enables in order (pe0,f0,a0..2), (pe0,f1,a0..2), (pe1,f0,…), (pe1,f1,a2) carrying data 11.
   - `o_done` coincides with the last enable.
2. Same config, valid toggling every other cycle: identical write sequence, no enable in gap cycles, counters hold.
3. `i_num_words` = 0: no enables; `o_done` 1 cycle after start; `o_busy` high for 1 cycle.
4. `i_num_words` = 7 with RAM_DEPTH = 4: clamped; 16 writes with addr never above 3.
5. `i_start` repulsed mid-load, then `reset` asserted after beat 5:
   - The repulse has no effect.
   - Next cycle all outputs are at reset values and no done pulse appears.
   - A fresh load then completes normally.
6. With `FILTER_CACHE_LOADER_ABORT_EN` defined, `i_abort` at beat 4:
   - IDLE next cycle, at most 4 enables, no `o_done`.
   - A subsequent start begins at (pe0, f0, a0).

Source files
------------

// File: rtl/filter_cache_loader_pkg.sv
// Shared types for the filter-cache write path: PE geometry, write-beat layout,
// loader state encoding and an ID-width helper.
package filter_cache_loader_pkg;

  localparam int NUM_FILTERS     = 2;
  localparam int RAM_DEPTH       = 4;
  localparam int RAM_ADDR_WIDTH  = 2;
  localparam int RAM_WIDTH       = 16;
  localparam int PE_ID_MAX_WIDTH = 4;

  typedef struct packed {
    int num_filters;
    int ram_depth;
    int ram_addr_width;
    int ram_width;
  } pe_cfg_t;

  localparam pe_cfg_t PE_CFG = '{
    num_filters:    NUM_FILTERS,
    ram_depth:      RAM_DEPTH,
    ram_addr_width: RAM_ADDR_WIDTH,
    ram_width:      RAM_WIDTH
  };

  // Width of an ID field able to hold 0..count-1; never narrower than one bit.
  function automatic int pe_id_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  localparam int FILTER_ID_WIDTH = pe_id_width(NUM_FILTERS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH
  } filter_loader_state_t;

  typedef struct packed {
    logic                       enable;
    logic [PE_ID_MAX_WIDTH-1:0] pe_id;
    logic [FILTER_ID_WIDTH-1:0] filter_id;
    logic [RAM_ADDR_WIDTH-1:0]  addr;
    logic [RAM_WIDTH-1:0]       data;
  } ram_write_request_t;

endpackage

// File: rtl/filter_cache_addr_gen.sv
// Nested addr (inner) / filter / pe (outer) counters with clear and advance;
// o_last flags the final position of a walk. Shared by the write and read sides.
module filter_cache_addr_gen
  import filter_cache_loader_pkg::*;
#(
  parameter pe_cfg_t cfg     = PE_CFG,
  parameter int      NUM_PES = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_clear,
  input  logic                       i_advance,
  input  logic [RAM_ADDR_WIDTH:0]    i_num_words,
  output logic [RAM_ADDR_WIDTH-1:0]  o_addr,
  output logic [FILTER_ID_WIDTH-1:0] o_filter,
  output logic [PE_ID_MAX_WIDTH-1:0] o_pe,
  output logic                       o_last
);

  localparam int PW = pe_id_width(NUM_PES);
  localparam logic [RAM_ADDR_WIDTH:0]    ONE_N  = (RAM_ADDR_WIDTH+1)'(1);
  localparam logic [FILTER_ID_WIDTH-1:0] F_LAST = FILTER_ID_WIDTH'(cfg.num_filters - 1);
  localparam logic [PW-1:0]              P_LAST = PW'(NUM_PES - 1);

  logic [RAM_ADDR_WIDTH-1:0]  addr_q,   addr_d;
  logic [FILTER_ID_WIDTH-1:0] filter_q, filter_d;
  logic [PW-1:0]              pe_q,     pe_d;
  logic addr_wrap, filter_wrap, pe_wrap;

  assign addr_wrap   = ({1'b0, addr_q} == (i_num_words - ONE_N));
  assign filter_wrap = (filter_q == F_LAST);
  assign pe_wrap     = (pe_q == P_LAST);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    addr_d   = addr_q;
    filter_d = filter_q;
    pe_d     = pe_q;
    if (i_clear) begin
      addr_d   = '0;
      filter_d = '0;
      pe_d     = '0;
    end else if (i_advance) begin
      if (addr_wrap) begin
        addr_d = '0;
        if (filter_wrap) begin
          filter_d = '0;
          pe_d     = pe_wrap ? '0 : pe_q + PW'(1);
        end else begin
          filter_d = filter_q + FILTER_ID_WIDTH'(1);
        end
      end else begin
        addr_d = addr_q + RAM_ADDR_WIDTH'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q   <= '0;
      filter_q <= '0;
      pe_q     <= '0;
    end else begin
      addr_q   <= addr_d;
      filter_q <= filter_d;
      pe_q     <= pe_d;
    end
  end

  assign o_addr   = addr_q;
  assign o_filter = filter_q;
  assign o_pe     = PE_ID_MAX_WIDTH'(pe_q);
  assign o_last   = addr_wrap && filter_wrap && pe_wrap;

endmodule

// File: rtl/filter_cache_loader.sv
// Write-side sequencer for the per-PE filter caches: turns a word stream into
// broadcast pe_ram write beats. Optional abort input: FILTER_CACHE_LOADER_ABORT_EN.
module filter_cache_loader
  import filter_cache_loader_pkg::*;
#(
  parameter pe_cfg_t cfg     = PE_CFG,
  parameter int      NUM_PES = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_start,
  input  logic [RAM_ADDR_WIDTH:0]   i_num_words,
  input  logic                      i_data_valid,
  input  logic [RAM_WIDTH-1:0]      i_data,
`ifdef FILTER_CACHE_LOADER_ABORT_EN
  input  logic                      i_abort,
`endif
  output logic                      o_data_ready,
  output ram_write_request_t        o_write_request,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam logic [RAM_ADDR_WIDTH:0] N_DEPTH = (RAM_ADDR_WIDTH+1)'(cfg.ram_depth);

  filter_loader_state_t state_q, state_d;
  logic [RAM_ADDR_WIDTH:0] n_q, n_d, n_clamp;
  logic ready_q, ready_d;
  ram_write_request_t wr_q, wr_d;

  logic abort_w, accept, gen_clear, gen_advance, gen_last;
  logic [RAM_ADDR_WIDTH-1:0]  gen_addr;
  logic [FILTER_ID_WIDTH-1:0] gen_filter;
  logic [PE_ID_MAX_WIDTH-1:0] gen_pe;

`ifdef FILTER_CACHE_LOADER_ABORT_EN
  assign abort_w = i_abort;
`else
  assign abort_w = 1'b0;
`endif

  assign n_clamp = (i_num_words > N_DEPTH) ? N_DEPTH : i_num_words;
  assign accept  = (state_q == ST_LOAD) && ready_q && i_data_valid;

  filter_cache_addr_gen #(
    .cfg     (cfg),
    .NUM_PES (NUM_PES)
  ) u_addr_gen (
    .clock       (clock),
    .reset       (reset),
    .i_clear     (gen_clear),
    .i_advance   (gen_advance),
    .i_num_words (n_q),
    .o_addr      (gen_addr),
    .o_filter    (gen_filter),
    .o_pe        (gen_pe),
    .o_last      (gen_last)
  );

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    ready_d     = ready_q;
    gen_clear   = 1'b0;
    gen_advance = 1'b0;
    wr_d        = wr_q;
    wr_d.enable = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          n_d       = n_clamp;
          gen_clear = 1'b1;
          if (n_clamp == '0) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_LOAD;
            ready_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          gen_advance    = 1'b1;
          wr_d.enable    = 1'b1;
          wr_d.pe_id     = gen_pe;
          wr_d.filter_id = gen_filter;
          wr_d.addr      = gen_addr;
          wr_d.data      = i_data;
          if (gen_last) begin
            state_d = ST_FLUSH;
            ready_d = 1'b0;
          end
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // An abort drops the beat accepted this cycle; one registered earlier still shows.
    if (abort_w && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      ready_d     = 1'b0;
      gen_clear   = 1'b1;
      gen_advance = 1'b0;
      wr_d        = wr_q;
      wr_d.enable = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      ready_q <= 1'b0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
    end
  end

  assign o_data_ready    = ready_q;
  assign o_write_request = wr_q;
  assign o_busy          = (state_q != ST_IDLE);
  assign o_done          = (state_q == ST_FLUSH) && !abort_w;

endmodule

// File: tb/tb_filter_cache_loader.sv
// Directed bench for filter_cache_loader with NUM_PES = 2, NUM_FILTERS = 2,
// RAM_DEPTH = 4; abort scenario runs when FILTER_CACHE_LOADER_ABORT_EN is defined.
module tb_filter_cache_loader;
  import filter_cache_loader_pkg::*;

  localparam int NP = 2;

  logic clock = 1'b0;
  logic reset;
  logic i_start;
  logic [RAM_ADDR_WIDTH:0] i_num_words;
  logic i_data_valid;
  logic [RAM_WIDTH-1:0] i_data;
`ifdef FILTER_CACHE_LOADER_ABORT_EN
  logic i_abort;
`endif
  logic o_data_ready, o_busy, o_done;
  ram_write_request_t o_write_request;

  int passed = 0;
  int total  = 0;

  ram_write_request_t cap[$];
  int cap_cyc[$];
  int done_cnt, done_with_en, done_cyc, busy_cnt, start_cyc;
  int cyc = 0;

  filter_cache_loader #(
    .cfg     (PE_CFG),
    .NUM_PES (NP)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .i_start         (i_start),
    .i_num_words     (i_num_words),
    .i_data_valid    (i_data_valid),
    .i_data          (i_data),
`ifdef FILTER_CACHE_LOADER_ABORT_EN
    .i_abort         (i_abort),
`endif
    .o_data_ready    (o_data_ready),
    .o_write_request (o_write_request),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Outputs are sampled on the falling edge, half a cycle after they settle.
  always @(negedge clock) begin
    if (o_write_request.enable === 1'b1) begin
      cap.push_back(o_write_request);
      cap_cyc.push_back(cyc);
    end
    if (o_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      if (o_write_request.enable === 1'b1) done_with_en++;
    end
    if (o_busy === 1'b1) busy_cnt++;
  end

  function automatic ram_write_request_t mk(input int p, input int f, input int a, input int d);
    ram_write_request_t r;
    r.enable    = 1'b1;
    r.pe_id     = PE_ID_MAX_WIDTH'(p);
    r.filter_id = FILTER_ID_WIDTH'(f);
    r.addr      = RAM_ADDR_WIDTH'(a);
    r.data      = RAM_WIDTH'(d);
    return r;
  endfunction

  task automatic clear_mon();
    cap.delete();
    cap_cyc.delete();
    done_cnt     = 0;
    done_with_en = 0;
    done_cyc     = -1;
    busy_cnt     = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start_load(input int nw);
    @(negedge clock);
    start_cyc   = cyc;
    i_start     = 1'b1;
    i_num_words = (RAM_ADDR_WIDTH+1)'(nw);
    @(negedge clock);
    i_start = 1'b0;
  endtask

  // Drives words 0,1,2,... until `beats` are accepted; gap toggles valid every cycle.
  // restart_at >= 0 pulses i_start while that beat index is being offered.
  task automatic feed(input int beats, input bit gap, input int restart_at, output int accepted);
    int d;
    int budget;
    bit phase;
    d = 0;
    budget = 0;
    phase = 1'b0;
    accepted = 0;
    while (accepted < beats && budget < 400) begin
      @(negedge clock);
      i_data       = RAM_WIDTH'(d);
      i_data_valid = gap ? phase : 1'b1;
      phase        = ~phase;
      i_start      = (accepted == restart_at);
      i_num_words  = (accepted == restart_at) ? (RAM_ADDR_WIDTH+1)'(1) : i_num_words;
      if (i_data_valid && o_data_ready === 1'b1) begin
        accepted++;
        d++;
      end
      budget++;
    end
    @(negedge clock);
    i_data_valid = 1'b0;
    i_start      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    total++;
    if (o_data_ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", o_data_ready);
    else passed++;
    total++;
    if (o_busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", o_busy);
    else passed++;
    total++;
    if (o_done !== 1'b0) $display("FAIL reset_done got=%b want=0", o_done);
    else passed++;
    total++;
    if (o_write_request !== '0) $display("FAIL reset_wr got=%h want=0", o_write_request);
    else passed++;
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_stream(input bit gap, input string tag);
    int acc;
    clear_mon();
    start_load(3);
    feed(12, gap, -1, acc);
    idle(3);
    total++;
    if (acc != 12) $display("FAIL %s_accepted got=%0d want=12", tag, acc);
    else passed++;
    total++;
    if (cap.size() != 12) $display("FAIL %s_count got=%0d want=12", tag, cap.size());
    else passed++;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (i >= cap.size()) $display("FAIL %s_beat%0d got=none want=%h", tag, i, mk(i / 6, (i / 3) % 2, i % 3, i));
      else if (cap[i] !== mk(i / 6, (i / 3) % 2, i % 3, i))
        $display("FAIL %s_beat%0d got=%h want=%h", tag, i, cap[i], mk(i / 6, (i / 3) % 2, i % 3, i));
      else passed++;
    end
    total++;
    if (done_cnt != 1 || done_with_en != 1)
      $display("FAIL %s_done got=cnt%0d/with_en%0d want=1/1", tag, done_cnt, done_with_en);
    else passed++;
    total++;
    if (o_busy !== 1'b0 || o_data_ready !== 1'b0)
      $display("FAIL %s_after got=busy%b/ready%b want=0/0", tag, o_busy, o_data_ready);
    else passed++;
    if (gap) begin
      for (int i = 1; i < cap_cyc.size(); i++) begin
        total++;
        if (cap_cyc[i] - cap_cyc[i-1] != 2)
          $display("FAIL %s_spacing%0d got=%0d want=2", tag, i, cap_cyc[i] - cap_cyc[i-1]);
        else passed++;
      end
    end
  endtask

  task automatic test_zero_words();
    clear_mon();
    start_load(0);
    idle(4);
    total++;
    if (cap.size() != 0) $display("FAIL zero_writes got=%0d want=0", cap.size());
    else passed++;
    total++;
    if (done_cnt != 1 || done_cyc != start_cyc + 1)
      $display("FAIL zero_done got=cnt%0d/cyc%0d want=1/%0d", done_cnt, done_cyc, start_cyc + 1);
    else passed++;
    total++;
    if (busy_cnt != 1) $display("FAIL zero_busy got=%0d want=1", busy_cnt);
    else passed++;
  endtask

  task automatic test_clamp();
    int acc;
    int bad_addr;
    clear_mon();
    start_load(7);
    feed(16, 1'b0, -1, acc);
    idle(3);
    bad_addr = 0;
    foreach (cap[i]) if (cap[i].addr > RAM_ADDR_WIDTH'(3)) bad_addr++;
    total++;
    if (cap.size() != 16) $display("FAIL clamp_count got=%0d want=16", cap.size());
    else passed++;
    total++;
    if (bad_addr != 0) $display("FAIL clamp_addr got=%0d_over want=0_over", bad_addr);
    else passed++;
    total++;
    if (cap.size() < 16) $display("FAIL clamp_last got=none want=%h", mk(1, 1, 3, 15));
    else if (cap[15] !== mk(1, 1, 3, 15)) $display("FAIL clamp_last got=%h want=%h", cap[15], mk(1, 1, 3, 15));
    else passed++;
    total++;
    if (done_cnt != 1 || done_with_en != 1)
      $display("FAIL clamp_done got=cnt%0d/with_en%0d want=1/1", done_cnt, done_with_en);
    else passed++;
  endtask

  task automatic test_restart_and_reset();
    int acc;
    clear_mon();
    start_load(3);
    feed(5, 1'b0, 2, acc);
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (o_data_ready !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_write_request !== '0)
      $display("FAIL midreset_outputs got=r%b/b%b/d%b/w%h want=0/0/0/0",
               o_data_ready, o_busy, o_done, o_write_request);
    else passed++;
    reset = 1'b0;
    idle(3);
    total++;
    if (cap.size() != 5) $display("FAIL midreset_count got=%0d want=5", cap.size());
    else passed++;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= cap.size()) $display("FAIL midreset_beat%0d got=none want=%h", i, mk(0, i / 3, i % 3, i));
      else if (cap[i] !== mk(0, i / 3, i % 3, i))
        $display("FAIL midreset_beat%0d got=%h want=%h", i, cap[i], mk(0, i / 3, i % 3, i));
      else passed++;
    end
    total++;
    if (done_cnt != 0) $display("FAIL midreset_nodone got=%0d want=0", done_cnt);
    else passed++;

    clear_mon();
    start_load(2);
    feed(8, 1'b0, -1, acc);
    idle(3);
    total++;
    if (cap.size() != 8 || done_cnt != 1)
      $display("FAIL fresh_load got=n%0d/done%0d want=8/1", cap.size(), done_cnt);
    else passed++;
    total++;
    if (cap.size() < 8) $display("FAIL fresh_last got=none want=%h", mk(1, 1, 1, 7));
    else if (cap[7] !== mk(1, 1, 1, 7)) $display("FAIL fresh_last got=%h want=%h", cap[7], mk(1, 1, 1, 7));
    else passed++;
  endtask

`ifdef FILTER_CACHE_LOADER_ABORT_EN
  task automatic test_abort();
    int acc;
    clear_mon();
    start_load(3);
    feed(3, 1'b0, -1, acc);
    @(negedge clock);
    i_data       = RAM_WIDTH'(3);
    i_data_valid = 1'b1;
    i_abort      = 1'b1;
    @(negedge clock);
    i_data_valid = 1'b0;
    i_abort      = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_data_ready !== 1'b0)
      $display("FAIL abort_idle got=busy%b/ready%b want=0/0", o_busy, o_data_ready);
    else passed++;
    idle(3);
    total++;
    if (cap.size() != 3) $display("FAIL abort_count got=%0d want=3", cap.size());
    else passed++;
    total++;
    if (done_cnt != 0) $display("FAIL abort_nodone got=%0d want=0", done_cnt);
    else passed++;

    clear_mon();
    start_load(1);
    feed(4, 1'b0, -1, acc);
    idle(3);
    total++;
    if (cap.size() != 4) $display("FAIL after_abort_count got=%0d want=4", cap.size());
    else passed++;
    total++;
    if (cap.size() < 1) $display("FAIL after_abort_first got=none want=%h", mk(0, 0, 0, 0));
    else if (cap[0] !== mk(0, 0, 0, 0)) $display("FAIL after_abort_first got=%h want=%h", cap[0], mk(0, 0, 0, 0));
    else passed++;
  endtask
`endif

  initial begin
    reset        = 1'b1;
    i_start      = 1'b0;
    i_num_words  = '0;
    i_data_valid = 1'b0;
    i_data       = '0;
`ifdef FILTER_CACHE_LOADER_ABORT_EN
    i_abort      = 1'b0;
`endif
    clear_mon();
    test_reset();
    test_stream(1'b0, "stream");
    test_stream(1'b1, "gapped");
    test_zero_words();
    test_clamp();
    test_restart_and_reset();
`ifdef FILTER_CACHE_LOADER_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
